cpu_divider_iter: RTL

Parametrised iterative integer divider for the CPU execute stage; successor to the fixed 32-bit radix-2 divider.
- Generalised in operand width (XLEN) and bits retired per cycle (radix 2^BITS_PER_CYCLE).
- Adds valid/ready request and response handshakes, a kill input for pipeline flush, and a divide-by-zero fast path.
- Implements RISC-V DIV/DIVU/REM/REMU semantics.

---
 rtl/cpu_div_pkg.sv | 18 +
 rtl/cpu_divider_step.sv | 44 ++++
 rtl/cpu_divider_iter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the iterative CPU divider.
// Used by cpu_divider_iter and cpu_divider_step.
package cpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int OP_SIGNED_BIT = 1;
  localparam int OP_QUOT_BIT   = 0;

  function automatic int unsigned div_cycles(input int unsigned xlen, input int unsigned bpc);
    return xlen / bpc;
  endfunction

endpackage

// File: rtl/cpu_divider_step.sv
// One combinational radix-2^BITS_PER_CYCLE restoring division step on magnitudes.
// Shifts the next dividend bits into the partial remainder and keeps the largest
// non-negative trial difference.
module cpu_divider_step
  import cpu_div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0]           rem_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [XLEN-1:0]           divisor_i,
  output logic [XLEN-1:0]           rem_o,
  output logic [BITS_PER_CYCLE-1:0] digit_o
);

  // One spare MSB holds the borrow of each trial subtraction.
  localparam int W = XLEN + BITS_PER_CYCLE + 1;

  logic [W-1:0] shifted;
  logic [W-1:0] mult;
  logic [W-1:0] trial;
  logic [W-1:0] best;

  // Trial differences shrink monotonically with the digit, so the last
  // non-negative one found on an ascending sweep is the largest digit that fits.
  always_comb begin
    shifted = {1'b0, rem_i, bits_i};
    best    = shifted;
    digit_o = '0;
    mult    = '0;
    trial   = '0;
    for (int d = 1; d < (1 << BITS_PER_CYCLE); d++) begin
      mult  = W'(divisor_i) * W'(d);
      trial = shifted - mult;
      if (!trial[W-1]) begin
        best    = trial;
        digit_o = BITS_PER_CYCLE'(d);
      end
    end
    rem_o = best[XLEN-1:0];
  end

endmodule

// File: rtl/cpu_divider_iter.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit with request/response handshakes and kill.
// Optional result cache for repeated operands: define DIVIDER_RESULT_CACHE_EN.
module cpu_divider_iter
  import cpu_div_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [1:0]      op_i,
  input  logic            kill_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] res_o
);

  localparam int unsigned NCYC = div_cycles(XLEN, BITS_PER_CYCLE);
  localparam int          CW   = $clog2(NCYC + 1);

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
      ((XLEN % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("cpu_divider_iter: BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
  end

  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     div_q, div_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                qNeg_q, qNeg_d;
  logic                rNeg_q, rNeg_d;
  logic                quotSel_q, quotSel_d;

  logic                opSigned;
  logic                aNeg;
  logic                bNeg;
  logic [XLEN-1:0]     magA;
  logic [XLEN-1:0]     magB;

  logic [XLEN-1:0]           stepRem;
  logic [BITS_PER_CYCLE-1:0] stepDigit;
  logic [XLEN-1:0]           quoNext;
  logic [XLEN-1:0]           quotFix;
  logic [XLEN-1:0]           remFix;

  logic                cacheHit;
  logic [XLEN-1:0]     cacheRes;

  assign opSigned = op_i[OP_SIGNED_BIT];
  assign aNeg     = opSigned & src_a_i[XLEN-1];
  assign bNeg     = opSigned & src_b_i[XLEN-1];
  assign magA     = aNeg ? -src_a_i : src_a_i;
  assign magB     = bNeg ? -src_b_i : src_b_i;

  // quo_q starts as |a| and fills with quotient digits from the bottom as the
  // dividend bits are consumed from the top.
  cpu_divider_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_i     (rem_q),
    .bits_i    (quo_q[XLEN-1 -: BITS_PER_CYCLE]),
    .divisor_i (div_q),
    .rem_o     (stepRem),
    .digit_o   (stepDigit)
  );

  assign quoNext = {quo_q[XLEN-BITS_PER_CYCLE-1:0], stepDigit};
  assign quotFix = qNeg_q ? -quoNext : quoNext;
  assign remFix  = rNeg_q ? -stepRem : stepRem;

`ifdef DIVIDER_RESULT_CACHE_EN
  logic            cacheValid_q;
  logic [XLEN-1:0] cacheA_q;
  logic [XLEN-1:0] cacheB_q;
  logic            cacheSigned_q;
  logic [XLEN-1:0] cacheQuot_q;
  logic [XLEN-1:0] cacheRem_q;
  logic [XLEN-1:0] opA_q;
  logic [XLEN-1:0] opB_q;
  logic            opSigned_q;
  logic            cacheLoad;

  assign cacheHit  = cacheValid_q && (src_a_i == cacheA_q) && (src_b_i == cacheB_q) &&
                     (opSigned == cacheSigned_q);
  assign cacheRes  = op_i[OP_QUOT_BIT] ? cacheQuot_q : cacheRem_q;
  assign cacheLoad = (state_q == CALC) && (cnt_q == CW'(1)) && !kill_i;

  // Raw operands are kept alongside the fixed-up results so a later request
  // can be matched exactly; only reset invalidates the entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cacheValid_q  <= 1'b0;
      cacheA_q      <= '0;
      cacheB_q      <= '0;
      cacheSigned_q <= 1'b0;
      cacheQuot_q   <= '0;
      cacheRem_q    <= '0;
      opA_q         <= '0;
      opB_q         <= '0;
      opSigned_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_valid_i && !kill_i) begin
        opA_q      <= src_a_i;
        opB_q      <= src_b_i;
        opSigned_q <= opSigned;
      end
      if (cacheLoad) begin
        cacheValid_q  <= 1'b1;
        cacheA_q      <= opA_q;
        cacheB_q      <= opB_q;
        cacheSigned_q <= opSigned_q;
        cacheQuot_q   <= quotFix;
        cacheRem_q    <= remFix;
      end
    end
  end
`else
  assign cacheHit = 1'b0;
  assign cacheRes = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      res_q     <= '0;
      qNeg_q    <= 1'b0;
      rNeg_q    <= 1'b0;
      quotSel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      res_q     <= res_d;
      qNeg_q    <= qNeg_d;
      rNeg_q    <= rNeg_d;
      quotSel_q <= quotSel_d;
    end
  end

  // Kill wins over everything; results are sign-corrected once, on the
  // transition into DONE, so res_o is a plain register in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    res_d     = res_q;
    qNeg_d    = qNeg_q;
    rNeg_d    = rNeg_q;
    quotSel_d = quotSel_q;

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            qNeg_d    = aNeg ^ bNeg;
            rNeg_d    = aNeg;
            quotSel_d = op_i[OP_QUOT_BIT];
            rem_d     = '0;
            quo_d     = magA;
            div_d     = magB;
            if (src_b_i == '0) begin
              res_d   = op_i[OP_QUOT_BIT] ? '1 : src_a_i;
              state_d = DONE;
            end else if (cacheHit) begin
              res_d   = cacheRes;
              state_d = DONE;
            end else begin
              cnt_d   = CW'(NCYC);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = stepRem;
          quo_d = quoNext;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_d   = quotSel_q ? quotFix : remFix;
            state_d = DONE;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign res_o       = res_q;

endmodule
